// File: rtl/carrd_wb_arbiter.sv
// Registered writeback stage: round-robin arbitration of NUM_SRC result channels into
// one vector/scalar register-file write per cycle, with a one-cycle output register.
module carrd_wb_arbiter #(
    parameter int NUM_SRC = 5,
    parameter int LANES   = 4,
    parameter int LANE_W  = 128,
    parameter int ADDR_W  = 5,
    localparam int SRC_W  = $clog2(NUM_SRC),
    localparam int ROW_W  = LANES * LANE_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SRC-1:0]         src_valid,
    output logic [NUM_SRC-1:0]         src_ready,
    input  logic [NUM_SRC*ROW_W-1:0]   src_data,
    input  logic [NUM_SRC*2-1:0]       src_dest,
    input  logic [NUM_SRC*ADDR_W-1:0]  src_addr,
    input  logic [NUM_SRC-1:0]         src_scalar,
    input  logic                       wb_stall,
    output logic                       v_reg_wr_en,
    output logic                       x_reg_wr_en,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [ROW_W-1:0]           reg_wr_data,
    output logic [SRC_W-1:0]           wb_src,
    output logic                       dest_err
);

    logic [SRC_W-1:0]   r_rr_ptr;
    logic               r_v_wr_en;
    logic               r_x_wr_en;
    logic               r_dest_err;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [ROW_W-1:0]   r_wr_data;
    logic [SRC_W-1:0]   r_wb_src;

    logic [NUM_SRC-1:0] w_grant;
    logic               w_any;
    logic [SRC_W-1:0]   w_gnt_idx;
    logic [SRC_W-1:0]   w_cand;
    logic [1:0]         w_dest;
    logic [ADDR_W-1:0]  w_addr;
    logic [ROW_W-1:0]   w_wdata;

    // Search from rr_ptr upward with wrap; reset also holds off every handshake.
    always_comb begin
        w_grant   = '0;
        w_any     = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_cand = SRC_W'((int'(r_rr_ptr) + k) % NUM_SRC);
            if (!w_any && !wb_stall && !rst && src_valid[w_cand]) begin
                w_any           = 1'b1;
                w_gnt_idx       = w_cand;
                w_grant[w_cand] = 1'b1;
            end
        end
    end

    always_comb begin
        w_dest  = src_dest[int'(w_gnt_idx)*2 +: 2];
        w_addr  = src_addr[int'(w_gnt_idx)*ADDR_W +: ADDR_W];
        w_wdata = src_data[int'(w_gnt_idx)*ROW_W +: ROW_W];
        if (src_scalar[w_gnt_idx]) begin
            w_wdata                = '0;
            w_wdata[LANE_W-1:0]    = src_data[int'(w_gnt_idx)*ROW_W +: LANE_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr   <= '0;
            r_v_wr_en  <= 1'b0;
            r_x_wr_en  <= 1'b0;
            r_dest_err <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_wb_src   <= '0;
        end else begin
            r_v_wr_en  <= w_any && (w_dest == 2'd1);
            r_x_wr_en  <= w_any && (w_dest == 2'd2);
            r_dest_err <= w_any && (w_dest == 2'd3);
            if (w_any) begin
                r_wr_addr <= w_addr;
                r_wr_data <= w_wdata;
                r_wb_src  <= w_gnt_idx;
                r_rr_ptr  <= (w_gnt_idx == SRC_W'(NUM_SRC - 1)) ? '0 : w_gnt_idx + 1'b1;
            end
        end
    end

    assign src_ready   = w_grant;
    assign v_reg_wr_en = r_v_wr_en;
    assign x_reg_wr_en = r_x_wr_en;
    assign dest_err    = r_dest_err;
    assign wr_addr     = r_wr_addr;
    assign reg_wr_data = r_wr_data;
    assign wb_src      = r_wb_src;

endmodule
